// File: rtl/demux_pkg.sv
// Shared constants for the 1:4 stream demux: word/channel widths and the select
// encoding shared with the 4:1 word mux.
package demux_pkg;

    localparam int WORD_W = 32;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    localparam logic [1:0] SEL_CH0 = 2'b11;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_CH3 = 2'b00;

    function automatic logic [1:0] sel_to_ch(input logic [1:0] sel);
        logic [1:0] ch;
        ch = 2'd0;
        case (sel)
            SEL_CH0: ch = 2'd0;
            SEL_CH1: ch = 2'd1;
            SEL_CH2: ch = 2'd2;
            SEL_CH3: ch = 2'd3;
            default: ch = 2'd0;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Purpose: DEPTH x WORD_W synchronous FIFO with registered head, storage cleared on reset.
// Latency: a pushed word is visible at head one cycle later when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; full is registered state only.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_dat,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra MSB is the wrap bit: equal index with differing wrap means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_router.sv
// Purpose: routes 32-bit words to one of four per-channel FIFOs by s_sel; DEMUX_STATS_EN adds accept counters.
// Latency: 1 cycle from accept to m_valid on an empty channel.
// Backpressure: s_ready = !full of the selected channel only; m_ready never reaches s_ready.
module demux_router
    import demux_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic [1:0]        s_sel,
    output logic [NUM_CH-1:0] m_valid,
    input  logic [NUM_CH-1:0] m_ready,
    output logic [WORD_W-1:0] m_data0,
    output logic [WORD_W-1:0] m_data1,
    output logic [WORD_W-1:0] m_data2,
    output logic [WORD_W-1:0] m_data3
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
`endif
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WORD_W-1:0] head [NUM_CH];
    logic [1:0]        ch;
    logic              accept;

    assign ch      = sel_to_ch(s_sel);
    assign s_ready = !full[ch];
    assign accept  = s_valid && s_ready;
    assign m_valid = ~empty;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = accept && (ch == 2'(i));
        assign pop[i]  = !empty[i] && m_ready[i];

        demux_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .push_dat (s_data),
            .pop      (pop[i]),
            .full     (full[i]),
            .empty    (empty[i]),
            .head     (head[i])
        );
    end

    assign m_data0 = head[0];
    assign m_data1 = head[1];
    assign m_data2 = head[2];
    assign m_data3 = head[3];

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_router.sv
// Testbench for demux_router: reset/table/directed corner cases plus a random run
// against a queue-based model; counter checks only when DEMUX_STATS_EN is defined.
module tb_demux_router;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [1:0]  s_sel;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [31:0] m_data0, m_data1, m_data2, m_data3;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int tests;
    int fails;

    demux_router #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data0 (m_data0),
        .m_data1 (m_data1),
        .m_data2 (m_data2),
        .m_data3 (m_data3)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .cnt3    (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel addressed by each select value: 00->3, 01->1, 10->2, 11->0.
    int sel2ch [4] = '{3, 1, 2, 0};

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  exp_vld;
        int          exp_ch;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] md(input int i);
        case (i)
            0: return m_data0;
            1: return m_data1;
            2: return m_data2;
            default: return m_data3;
        endcase
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sel   = 2'b00;
        s_data  = 32'h0;
        m_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [1:0] sel, input logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    vec_t        tbl [8];
    logic [31:0] q [4][$];
    int          ch;
    logic        exp_rdy;
    int unsigned acc [4];
    int unsigned n_acc;

    initial begin
        tests = 0;
        fails = 0;

        // Reset state
        do_reset();
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data0", m_data0, 32'h0);
        chk("rst_m_data1", m_data1, 32'h0);
        chk("rst_m_data2", m_data2, 32'h0);
        chk("rst_m_data3", m_data3, 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
`ifdef DEMUX_STATS_EN
        chk("rst_cnt", {cnt0, cnt1} | {cnt2, cnt3}, 32'h0);
`endif

        // Reset then single word to ch1
        m_ready = 4'h0;
        push_word(2'b01, 32'hDEADBEEF);
        chk("single_m_valid", 32'(m_valid), 32'h2);
        chk("single_m_data1", m_data1, 32'hDEADBEEF);

        // Table: one word per select, then a second word fills the channel
        tbl[0] = '{2'b11, 32'h0000_00A0, 4'b0001, 0};
        tbl[1] = '{2'b01, 32'h1111_00B1, 4'b0010, 1};
        tbl[2] = '{2'b10, 32'h2222_00C2, 4'b0100, 2};
        tbl[3] = '{2'b00, 32'h3333_00D3, 4'b1000, 3};
        tbl[4] = '{2'b00, 32'hFFFF_FFFF, 4'b1000, 3};
        tbl[5] = '{2'b11, 32'h8000_0001, 4'b0001, 0};
        tbl[6] = '{2'b10, 32'h0000_0000, 4'b0100, 2};
        tbl[7] = '{2'b01, 32'h5A5A_A5A5, 4'b0010, 1};
        for (int k = 0; k < 8; k++) begin
            do_reset();
            push_word(tbl[k].sel, tbl[k].data);
            chk("tbl_m_valid", 32'(m_valid), 32'(tbl[k].exp_vld));
            chk("tbl_m_data", md(tbl[k].exp_ch), tbl[k].data);
            s_sel = tbl[k].sel;
            #1;
            chk("tbl_s_ready_one", 32'(s_ready), 32'h1);
            push_word(tbl[k].sel, ~tbl[k].data);
            s_sel = tbl[k].sel;
            #1;
            chk("tbl_s_ready_full", 32'(s_ready), 32'h0);
            chk("tbl_head_kept", md(tbl[k].exp_ch), tbl[k].data);
        end

        // Full and backpressure on ch3
        do_reset();
        push_word(2'b00, 32'h1);
        push_word(2'b00, 32'h2);
        s_sel = 2'b00;
        #1;
        chk("bp_ready_sel00", 32'(s_ready), 32'h0);
        s_sel = 2'b11;
        #1;
        chk("bp_ready_sel11", 32'(s_ready), 32'h1);
        m_ready = 4'b1000;
        #1;
        chk("bp_pop1", m_data3, 32'h1);
        @(posedge clk);
        #1;
        chk("bp_pop2_vld", 32'(m_valid), 32'h8);
        chk("bp_pop2", m_data3, 32'h2);
        @(posedge clk);
        #1;
        chk("bp_drained", 32'(m_valid), 32'h0);
        m_ready = 4'h0;

        // Full + same-cycle pop on ch0
        do_reset();
        push_word(2'b11, 32'hA000_0000);
        push_word(2'b11, 32'hB000_0000);
        m_ready = 4'b0001;
        s_valid = 1'b1;
        s_sel   = 2'b11;
        s_data  = 32'hC000_0000;
        #1;
        chk("fp_ready_full", 32'(s_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("fp_ready_next", 32'(s_ready), 32'h1);
        chk("fp_head_b", m_data0, 32'hB000_0000);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("fp_vld_c", 32'(m_valid), 32'h1);
        chk("fp_head_c", m_data0, 32'hC000_0000);
        m_ready = 4'h0;

        // Interleaved channels, all consumers ready
        do_reset();
        m_ready = 4'hF;
        push_word(2'b11, 32'hAAAA_0001);
        chk("il_vld_a", 32'(m_valid), 32'h1);
        chk("il_data_a", m_data0, 32'hAAAA_0001);
        push_word(2'b01, 32'hBBBB_0002);
        chk("il_vld_b", 32'(m_valid), 32'h2);
        chk("il_data_b", m_data1, 32'hBBBB_0002);
        push_word(2'b10, 32'hCCCC_0003);
        chk("il_vld_c", 32'(m_valid), 32'h4);
        chk("il_data_c", m_data2, 32'hCCCC_0003);
        push_word(2'b00, 32'hDDDD_0004);
        chk("il_vld_d", 32'(m_valid), 32'h8);
        chk("il_data_d", m_data3, 32'hDDDD_0004);
        @(posedge clk);
        #1;
        chk("il_vld_end", 32'(m_valid), 32'h0);

        // Async reset mid-stream with ch2 holding two words
        do_reset();
        push_word(2'b10, 32'h2020_0001);
        push_word(2'b10, 32'h2020_0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_m_valid", 32'(m_valid), 32'h0);
        chk("ar_m_data2", m_data2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("ar_no_pops", 32'(m_valid), 32'h0);
        m_ready = 4'h0;
        push_word(2'b01, 32'h7777_1234);
        chk("ar_lat_vld", 32'(m_valid), 32'h2);
        chk("ar_lat_data", m_data1, 32'h7777_1234);

        // Random traffic against queue model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            acc[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk("rnd_vld", 32'(m_valid[i]), 32'(q[i].size() > 0));
                if (q[i].size() > 0) chk("rnd_data", md(i), q[i][0]);
            end
            s_valid = ($urandom_range(0, 3) != 0);
            s_sel   = 2'($urandom);
            s_data  = $urandom;
            for (int i = 0; i < 4; i++) m_ready[i] = ($urandom_range(0, 2) == 0);
            #1;
            ch      = sel2ch[s_sel];
            exp_rdy = (q[ch].size() < DEPTH);
            chk("rnd_s_ready", 32'(s_ready), 32'(exp_rdy));
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() > 0 && m_ready[i]) void'(q[i].pop_front());
            end
            if (s_valid && exp_rdy) begin
                q[ch].push_back(s_data);
                acc[ch]++;
            end
        end
        #1;
        s_valid = 1'b0;
`ifdef DEMUX_STATS_EN
        chk("rnd_cnt0", 32'(cnt0), 32'(acc[0]));
        chk("rnd_cnt1", 32'(cnt1), 32'(acc[1]));
        chk("rnd_cnt2", 32'(cnt2), 32'(acc[2]));
        chk("rnd_cnt3", 32'(cnt3), 32'(acc[3]));

        // Counter saturation on ch1
        do_reset();
        m_ready = 4'b0010;
        s_sel   = 2'b01;
        s_data  = 32'h0;
        s_valid = 1'b1;
        n_acc   = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (s_ready) n_acc++;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("sat_cnt1", 32'(cnt1), (n_acc > 32'd65535) ? 32'hFFFF : 32'(n_acc));
        chk("sat_accepts", 32'(n_acc > 32'd65535), 32'h1);
        chk("sat_cnt0", 32'(cnt0), 32'h0);
        chk("sat_cnt2", 32'(cnt2), 32'h0);
        chk("sat_cnt3", 32'(cnt3), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
